// File: rtl/uart_tx_frame.sv
// UART transmitter frame stage: strobes on rising edges of baud_clk and serialises
// one accepted word as start, LSB-first data, optional parity and 1-2 stop bits.
module uart_tx_frame #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_clk,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   state_t                 state_q, state_d;
   logic                   tx_q, tx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic                   stop_cnt_q, stop_cnt_d;
   logic                   baud_dly_q;
   logic                   tick;

   // One-cycle strobe per baud_clk rising edge; each strobe closes one line bit.
   assign tick = baud_clk & ~baud_dly_q;

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      shift_d    = shift_q;
      par_d      = par_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (tx_valid) begin
               shift_d = tx_data;
               par_d   = (PARITY == 2) ? ^tx_data : ~^tx_data;
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (tick) begin
               tx_d    = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               tx_d      = shift_q[0];
               bit_cnt_d = 3'd0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_cnt_q < LAST_BIT) begin
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end else if (PARITY != 0) begin
                  tx_d    = par_q;
                  state_d = S_PARITY;
               end else begin
                  tx_d       = 1'b1;
                  stop_cnt_d = 1'b0;
                  state_d    = S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
               state_d    = S_STOP;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (tick) begin
               if (stop_cnt_q == LAST_STOP) begin
                  state_d = S_IDLE;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tx_q       <= 1'b1;
         bit_cnt_q  <= 3'd0;
         stop_cnt_q <= 1'b0;
         baud_dly_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         baud_dly_q <= baud_clk;
      end
   end

   // Payload registers carry no reset: they are always loaded before use.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      par_q   <= par_d;
   end

   assign tx       = tx_q;
   assign tx_ready = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);

endmodule
